// File: rtl/router_reg_gen.sv
// Router register stage: header latch, FIFO write path with full-hold, checksum and length check.
// Optional ROUTER_ERR_CNT_EN adds a saturating err_count output.
module router_reg_gen #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned CHK_MODE = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     packet_valid,
    input  logic [DATA_W-1:0]        datain,
    input  logic                     fifo_full,
    input  logic                     detect_add,
    input  logic                     lfd_state,
    input  logic                     ld_state,
    input  logic                     laf_state,
    input  logic                     full_state,
    input  logic                     rst_int_reg,
    output logic [DATA_W-1:0]        dout,
    output logic [DATA_W-ADDR_W-1:0] pkt_len,
    output logic                     parity_done,
    output logic                     low_packet_valid,
`ifdef ROUTER_ERR_CNT_EN
    output logic [CNT_W-1:0]         err_count,
`endif
    output logic                     err,
    output logic                     len_err
);

    localparam int unsigned LEN_W = DATA_W - ADDR_W;

    logic [DATA_W-1:0] header_reg;
    logic [DATA_W-1:0] hold_reg;
    logic [DATA_W-1:0] int_chk;
    logic [DATA_W-1:0] ext_chk;
    logic [LEN_W-1:0]  pay_cnt;
    logic              parity_prev;

    logic              addr_ok;
    logic              hdr_cap;
    logic              ld_act;
    logic              laf_act;
    logic              chk_fire;
    logic              chk_bad;
    logic              len_bad;
    logic [DATA_W-1:0] chk_next;

    // A header strobe suppresses any concurrent load/after-full strobe.
    always_comb begin
        addr_ok  = 32'(datain[ADDR_W-1:0]) < NUM_CH;
        hdr_cap  = detect_add & packet_valid & addr_ok;
        ld_act   = ld_state & ~detect_add;
        laf_act  = laf_state & ~detect_add;
        chk_bad  = int_chk != ext_chk;
        len_bad  = pay_cnt != pkt_len;
        chk_fire = parity_done & ~parity_prev & ~hdr_cap;
        chk_next = int_chk ^ datain;
        if (CHK_MODE == 1) begin
            chk_next = int_chk + datain;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout             <= '0;
            pkt_len          <= '0;
            parity_done      <= 1'b0;
            low_packet_valid <= 1'b0;
            err              <= 1'b0;
            len_err          <= 1'b0;
            header_reg       <= '0;
            hold_reg         <= '0;
            int_chk          <= '0;
            ext_chk          <= '0;
            pay_cnt          <= '0;
            parity_prev      <= 1'b0;
        end else begin
            if (lfd_state) begin
                dout <= header_reg;
            end else if (ld_act && !fifo_full) begin
                dout <= datain;
            end else if (ld_act) begin
                hold_reg <= datain;
            end else if (laf_act) begin
                dout <= hold_reg;
            end

            parity_prev <= parity_done;

            if (hdr_cap) begin
                header_reg  <= datain;
                pkt_len     <= datain[DATA_W-1:ADDR_W];
                int_chk     <= datain;
                pay_cnt     <= '0;
                parity_done <= 1'b0;
                err         <= 1'b0;
                len_err     <= 1'b0;
            end else begin
                if (ld_act && packet_valid && !full_state) begin
                    int_chk <= chk_next;
                    if (pay_cnt != '1) begin
                        pay_cnt <= pay_cnt + 1'b1;
                    end
                end
                if (ld_act && !packet_valid && !fifo_full) begin
                    ext_chk     <= datain;
                    parity_done <= 1'b1;
                end else if (laf_act && low_packet_valid && !parity_done) begin
                    // Checksum byte was parked in hold_reg while the FIFO was full.
                    ext_chk     <= hold_reg;
                    parity_done <= 1'b1;
                end
                if (chk_fire) begin
                    err     <= chk_bad;
                    len_err <= len_bad;
                end
            end

            if (rst_int_reg) begin
                low_packet_valid <= 1'b0;
            end else if (ld_act && !packet_valid) begin
                low_packet_valid <= 1'b1;
            end
        end
    end

`ifdef ROUTER_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (chk_fire && (chk_bad || len_bad) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_router_reg_gen.sv
// Scoreboard bench for router_reg_gen: XOR instance checked on the FIFO write path,
// a sum-mode instance shares the stimulus for checksum comparison.
module tb_router_reg_gen;

    logic       clk;
    logic       reset;
    logic       packet_valid;
    logic [7:0] datain;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;

    logic [7:0] dout0, dout1;
    logic [5:0] pkt_len0, pkt_len1;
    logic       parity_done0, parity_done1;
    logic       lpv0, lpv1;
    logic       err0, err1;
    logic       len_err0, len_err1;
`ifdef ROUTER_ERR_CNT_EN
    logic [7:0] err_count0, err_count1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       we_q;

    router_reg_gen #(.CHK_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .packet_valid(packet_valid), .datain(datain),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout0), .pkt_len(pkt_len0),
        .parity_done(parity_done0), .low_packet_valid(lpv0),
`ifdef ROUTER_ERR_CNT_EN
        .err_count(err_count0),
`endif
        .err(err0), .len_err(len_err0)
    );

    router_reg_gen #(.CHK_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .packet_valid(packet_valid), .datain(datain),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout1), .pkt_len(pkt_len1),
        .parity_done(parity_done1), .low_packet_valid(lpv1),
`ifdef ROUTER_ERR_CNT_EN
        .err_count(err_count1),
`endif
        .err(err1), .len_err(len_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a FIFO write is implied by the strobes seen at the edge; compare dout after it.
    always @(posedge clk) begin
        we_q <= !reset && (lfd_state || (!detect_add && ((ld_state && !fifo_full) || laf_state)));
    end

    always @(negedge clk) begin
        if (we_q) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", 32'(dout0), 32'hFFFF_FFFF);
            end else begin
                check("dout", 32'(dout0), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        packet_valid = 1'b0;
        datain       = 8'h00;
        fifo_full    = 1'b0;
        detect_add   = 1'b0;
        lfd_state    = 1'b0;
        ld_state     = 1'b0;
        laf_state    = 1'b0;
        full_state   = 1'b0;
        rst_int_reg  = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pay[4], input int n,
                            input logic [7:0] chk, input int full_at, input int exp_len,
                            input int e_err0, input int e_len, input int e_err1,
                            input int e_cnt);
        clr(); detect_add = 1'b1; packet_valid = 1'b1; datain = hdr;
        tick();
        check("pkt_len", 32'(pkt_len0), 32'(exp_len));
        clr(); lfd_state = 1'b1; packet_valid = 1'b1; datain = pay[0];
        exp_q.push_back(hdr);
        tick();
        for (int i = 0; i < n; i++) begin
            if (i == full_at) begin
                clr(); ld_state = 1'b1; packet_valid = 1'b1; fifo_full = 1'b1; datain = pay[i];
                tick();
                check("dout_hold_on_full", 32'(dout0), 32'(pay[i-1]));
                clr(); full_state = 1'b1; fifo_full = 1'b1; packet_valid = 1'b1;
                tick();
                clr(); laf_state = 1'b1; packet_valid = 1'b1;
                exp_q.push_back(pay[i]);
                tick();
            end else begin
                clr(); ld_state = 1'b1; packet_valid = 1'b1; datain = pay[i];
                exp_q.push_back(pay[i]);
                tick();
            end
        end
        clr(); ld_state = 1'b1; datain = chk;
        exp_q.push_back(chk);
        tick();
        check("parity_done", 32'(parity_done0), 32'd1);
        check("err_not_yet", 32'(err0), 32'd0);
        check("low_packet_valid", 32'(lpv0), 32'd1);
        clr();
        tick();
        check("err", 32'(err0), 32'(e_err0));
        check("len_err", 32'(len_err0), 32'(e_len));
        check("err_sum_mode", 32'(err1), 32'(e_err1));
`ifdef ROUTER_ERR_CNT_EN
        check("err_count", 32'(err_count0), 32'(e_cnt));
`endif
        clr(); rst_int_reg = 1'b1;
        tick();
        check("lpv_cleared", 32'(lpv0), 32'd0);
        check("parity_done_sticky", 32'(parity_done0), 32'd1);
        clr();
    endtask

    initial begin
        logic [7:0] p4[4];
        logic [7:0] p3[4];
        logic [7:0] p0[4];
        p4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        p3 = '{8'h11, 8'h22, 8'h33, 8'h00};
        p0 = '{8'h00, 8'h00, 8'h00, 8'h00};

        clr();
        reset = 1'b1;
        tick();
        tick();
        check("rst_dout", 32'(dout0), 32'd0);
        check("rst_pkt_len", 32'(pkt_len0), 32'd0);
        check("rst_parity_done", 32'(parity_done0), 32'd0);
        check("rst_err", 32'({err0, len_err0, lpv0}), 32'd0);
        reset = 1'b0;

        //       hdr    pay n  chk    full len err len_err err_sum cnt
        send_pkt(8'h12, p4, 4, 8'h56, -1,  4,  0,  0,      1,      0);
        send_pkt(8'h12, p4, 4, 8'hA5, -1,  4,  1,  0,      1,      1);
        send_pkt(8'h12, p4, 4, 8'hBC, -1,  4,  1,  0,      0,      2);
        send_pkt(8'h12, p4, 4, 8'h56, -1,  4,  0,  0,      1,      2);
        send_pkt(8'h12, p4, 4, 8'h56,  2,  4,  0,  0,      1,      2);
        send_pkt(8'h01, p0, 0, 8'h01, -1,  0,  0,  0,      0,      2);

        clr(); reset = 1'b1;
        tick();
        reset = 1'b0;
        detect_add = 1'b1; packet_valid = 1'b1; datain = 8'h13;
        tick();
        check("illegal_addr_pkt_len", 32'(pkt_len0), 32'd0);
        check("illegal_addr_dout", 32'(dout0), 32'd0);
        clr();

        send_pkt(8'h12, p3, 3, 8'h12, -1,  4,  0,  1,      1,      1);

        clr(); detect_add = 1'b1; packet_valid = 1'b1; datain = 8'h12;
        tick();
        clr(); lfd_state = 1'b1; packet_valid = 1'b1; exp_q.push_back(8'h12);
        tick();
        clr(); ld_state = 1'b1; packet_valid = 1'b1; datain = 8'h11; exp_q.push_back(8'h11);
        tick();
        clr(); ld_state = 1'b1; packet_valid = 1'b1; datain = 8'h22; reset = 1'b1;
        tick();
        check("midrst_dout", 32'(dout0), 32'd0);
        check("midrst_pkt_len", 32'(pkt_len0), 32'd0);
        check("midrst_flags", 32'({parity_done0, lpv0, err0, len_err0}), 32'd0);
`ifdef ROUTER_ERR_CNT_EN
        check("midrst_err_count", 32'(err_count0), 32'd0);
`endif
        reset = 1'b0;
        clr();
        tick();
        #10;
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_reg_gen.md
Name: router_reg_gen

Overview:
Parametrised successor to the router register stage of the 1xN router. It sits between the input interface and the per-channel FIFOs and is driven by the router FSM state strobes. It latches the header, routes header and payload bytes to the FIFO write bus, and holds bytes that arrive while the FIFO is full. It also computes a configurable packet checksum and checks both the checksum and the header-declared payload length.

Parameters:
DATA_W, 8, byte width of datain/dout.
ADDR_W, 2, header address field width, taken from header[ADDR_W-1:0]; LEN_W = DATA_W-ADDR_W.
NUM_CH, 3, number of output channels; a header address is legal if addr < NUM_CH.
CHK_MODE, 0, checksum mode: 0 = XOR parity, 1 = modulo-2^DATA_W sum.
CNT_W, 8, err_count width (used only with the optional feature).

Ports:
clk  in  1  clock; all logic is rising-edge.
reset  in  1  synchronous, active-high reset.
packet_valid  in  1  source byte valid; falling edge marks the checksum byte.
datain  in  DATA_W  packet byte: header = {len[LEN_W-1:0], addr[ADDR_W-1:0]}.
fifo_full  in  1  selected FIFO full.
detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  FSM state strobes.
rst_int_reg  in  1  FSM clear for low_packet_valid.
dout  out  DATA_W  FIFO write data.
pkt_len  out  LEN_W  latched header length.
parity_done  out  1  checksum byte captured.
low_packet_valid  out  1  packet_valid has dropped during load.
err  out  1  checksum mismatch.
len_err  out  1  payload count differs from pkt_len.

Behaviour:
- Reset: every output is 0; header_reg, hold_reg, int_chk, ext_chk and pay_cnt are 0. Reset beats every other condition.
- Header capture: when detect_add & packet_valid & addr<NUM_CH at an edge, the block loads header_reg<=datain, pkt_len<=len, int_chk<=datain, pay_cnt<=0, and clears parity_done, err and len_err. An illegal address causes no capture.
- dout priority, one edge of latency, otherwise dout holds:
  - lfd_state: dout<=header_reg.
  - else ld_state & !fifo_full: dout<=datain.
  - else ld_state & fifo_full: hold_reg<=datain and dout holds.
  - else laf_state: dout<=hold_reg.
- Accumulate: when ld_state & packet_valid & !full_state, int_chk<=int_chk^datain (CHK_MODE 0) or int_chk+datain truncated to DATA_W (CHK_MODE 1). In the same cycle pay_cnt increments, saturating at 2^LEN_W-1.
- Checksum byte capture:
  - ld_state & !packet_valid & !fifo_full: ext_chk<=datain and parity_done<=1.
  - laf_state & low_packet_valid & !parity_done: ext_chk<=hold_reg and parity_done<=1.
  - parity_done then stays at 1 until the next header capture or reset.
- low_packet_valid: set when ld_state & !packet_valid; cleared by rst_int_reg. If set and clear occur in the same cycle, the clear wins.
- Check: in the cycle after parity_done first rises, err<=(int_chk!=ext_chk) and len_err<=(pay_cnt!=pkt_len). Both are sticky until the next header capture or reset.
- pkt_len=0: a packet with no payload is legal; the header byte alone forms int_chk.
- A saturated pay_cnt with pkt_len < 2^LEN_W-1 produces len_err=1.
- detect_add wins over any concurrent ld/laf strobe. Reset mid-packet drops all state; the next packet needs a fresh detect_add.

Optional Feature:
ROUTER_ERR_CNT_EN
- Defined: adds output err_count[CNT_W-1:0], reset to 0. It increments by 1 in the cycle err or len_err is set, saturates at all-ones, and is cleared only by reset.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- XOR good packet (CHK_MODE 0): header 0x12 (len 4, addr 2), payload 0x11,0x22,0x33,0x44, checksum 0x56 -> dout sequence 0x12,0x11..0x44; parity_done=1; err=0, len_err=0.
- XOR bad checksum: same packet with checksum 0xA5 -> err=1 one cycle after parity_done; len_err=0.
- Sum mode (CHK_MODE 1): same header and payload, checksum 0xBC -> err=0. Checksum 0x56 -> err=1.
- FIFO full: fifo_full=1 on the 3rd payload byte 0x33 -> dout holds 0x22; hold_reg=0x33; laf_state -> dout=0x33. Final err=0.
- Length mismatch: header len 4, only 3 payload bytes, then a correct XOR checksum of those 4 bytes -> err=0, len_err=1. err_count=1 when ROUTER_ERR_CNT_EN is defined.
- Illegal address / reset: header addr 3 with NUM_CH=3 -> no capture, pkt_len stays 0. Reset asserted mid-payload -> all outputs 0 on the next edge.
